// File: rtl/comb_truth_checker_if.sv
// comb_truth_checker_if: bundle between the sweep checker and the block under test / controller.
// slave  : checker side (drives abcd_o and results, reads start and y_i)
// master : controller/DUT side (drives start and y_i, reads code and results)
interface comb_truth_checker_if;
    logic        start;
    logic        y_i;
    logic [3:0]  abcd_o;
    logic        busy;
    logic        done;
    logic        pass;
    logic [15:0] truth;
    logic [4:0]  mismatch_cnt;
    logic [3:0]  fail_idx;
    modport master (output start, y_i, input abcd_o, busy, done, pass, truth, mismatch_cnt, fail_idx);
    modport slave (input start, y_i, output abcd_o, busy, done, pass, truth, mismatch_cnt, fail_idx);
endinterface

// File: rtl/comb_truth_checker.sv
// comb_truth_checker: sweeps a 4-input combinational block over all 16 codes and judges its truth table.
// clk   : rising-edge clock
// rst_n : synchronous active-low reset
// bus   : start/y_i in; abcd_o, busy, done, pass, truth, mismatch_cnt, fail_idx out
module comb_truth_checker #(
    parameter int          SETTLE   = 2,
    parameter logic [15:0] EXPECTED = 16'hB2E8
) (
    input logic                  clk,
    input logic                  rst_n,
    comb_truth_checker_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, APPLY, SAMPLE, DONE} state_t;
    state_t      state, state_nx;
    logic [3:0]  idx, cnt, abcd, fail_idx;
    logic [15:0] truth;
    logic [4:0]  mm, mm_nx;
    logic        pass, busy, done, miss;

    assign miss  = bus.y_i != EXPECTED[idx];
    // count including the current sample, so the last code is reflected in pass
    assign mm_nx = mm + 5'(miss);

    always_ff @(posedge clk)
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = bus.start ? APPLY : IDLE;
            APPLY:   state_nx = cnt == 4'd0 ? SAMPLE : APPLY;
            SAMPLE:  state_nx = idx == 4'hF ? DONE : APPLY;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy = state == APPLY || state == SAMPLE;
        done = state == DONE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx      <= '0;
            cnt      <= '0;
            abcd     <= '0;
            truth    <= '0;
            mm       <= '0;
            fail_idx <= '0;
            pass     <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    idx      <= '0;
                    abcd     <= '0;
                    cnt      <= 4'(SETTLE - 1);
                    truth    <= '0;
                    mm       <= '0;
                    fail_idx <= '0;
                    pass     <= 1'b0;
                end
                APPLY: cnt <= cnt - 4'd1;
                SAMPLE: begin
                    truth[idx] <= bus.y_i;
                    mm         <= mm_nx;
                    if (miss && mm == 5'd0) fail_idx <= idx;
                    // last code: keep abcd at 4'hF instead of wrapping to 0
                    if (idx == 4'hF) pass <= mm_nx == 5'd0;
                    else begin
                        idx  <= idx + 4'd1;
                        abcd <= idx + 4'd1;
                        cnt  <= 4'(SETTLE - 1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.abcd_o       = abcd;
    assign bus.busy         = busy;
    assign bus.done         = done;
    assign bus.pass         = pass;
    assign bus.truth        = truth;
    assign bus.mismatch_cnt = mm;
    assign bus.fail_idx     = fail_idx;
endmodule

// File: tb/tb_comb_truth_checker.sv
// tb_comb_truth_checker: randomized/directed sweeps of comb_truth_checker against a truth-table reference.
module tb_comb_truth_checker;
    localparam logic [15:0] EXP = 16'hB2E8;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [15:0] model_a = '0, model_b = '0;
    int n_tests = 0, n_fail = 0;

    comb_truth_checker_if ifa ();
    comb_truth_checker_if ifb ();

    assign ifa.y_i = model_a[ifa.abcd_o];
    assign ifb.y_i = model_b[ifb.abcd_o];

    comb_truth_checker #(.SETTLE(2), .EXPECTED(EXP)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa.slave));
    comb_truth_checker #(.SETTLE(1), .EXPECTED(EXP)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb.slave));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input bit which);
        chk("rst_abcd", which ? ifb.abcd_o : ifa.abcd_o, 0);
        chk("rst_busy", which ? ifb.busy : ifa.busy, 0);
        chk("rst_done", which ? ifb.done : ifa.done, 0);
        chk("rst_pass", which ? ifb.pass : ifa.pass, 0);
        chk("rst_truth", which ? ifb.truth : ifa.truth, 0);
        chk("rst_mm", which ? ifb.mismatch_cnt : ifa.mismatch_cnt, 0);
        chk("rst_fail", which ? ifb.fail_idx : ifa.fail_idx, 0);
    endtask

    // One full sweep; the reference derives results directly from the model table.
    task automatic sweep(input bit which, input int s, input logic [15:0] tbl, input bit noise);
        int total, cnt, first;
        logic [15:0] diff;
        total = 16 * (s + 1);
        if (which) model_b = tbl; else model_a = tbl;
        diff = tbl ^ EXP;
        cnt = 0;
        first = -1;
        for (int i = 0; i < 16; i++) if (diff[i]) begin
            cnt++;
            if (first < 0) first = i;
        end
        @(negedge clk);
        chk("idle_done", which ? ifb.done : ifa.done, 0);
        chk("idle_busy", which ? ifb.busy : ifa.busy, 0);
        if (which) ifb.start = 1'b1; else ifa.start = 1'b1;
        @(posedge clk);
        #1 ifa.start = 1'b0;
        ifb.start = 1'b0;
        for (int j = 0; j <= total; j++) begin
            @(negedge clk);
            if (which) ifb.start = 1'b0; else ifa.start = noise && (j == 10 || j == 30);
            chk($sformatf("abcd_c%0d", j), which ? ifb.abcd_o : ifa.abcd_o, j < total ? j / (s + 1) : 15);
            chk($sformatf("busy_c%0d", j), which ? ifb.busy : ifa.busy, j < total);
            chk($sformatf("done_c%0d", j), which ? ifb.done : ifa.done, j == total);
        end
        ifa.start = 1'b0;
        chk("truth", which ? ifb.truth : ifa.truth, tbl);
        chk("mismatch_cnt", which ? ifb.mismatch_cnt : ifa.mismatch_cnt, cnt);
        chk("fail_idx", which ? ifb.fail_idx : ifa.fail_idx, first < 0 ? 0 : first);
        chk("pass", which ? ifb.pass : ifa.pass, cnt == 0);
    endtask

    initial begin
        bit saw_done;
        ifa.start = 1'b0;
        ifb.start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_zero(0);
        chk_zero(1);
        rst_n = 1'b1;
        sweep(0, 2, EXP, 0);
        sweep(0, 2, EXP, 0);
        sweep(0, 2, EXP ^ 16'h1020, 0);
        sweep(0, 2, 16'h0000, 0);
        sweep(1, 1, ~EXP, 0);
        sweep(1, 1, EXP, 0);
        sweep(0, 2, EXP, 1);
        for (int k = 0; k < 4; k++) sweep(0, 2, 16'($urandom), 0);
        sweep(0, 2, EXP ^ 16'h8001, 0);
        @(negedge clk);
        ifa.start = 1'b1;
        @(posedge clk);
        #1 ifa.start = 1'b0;
        repeat (19) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk_zero(0);
        saw_done = 1'b0;
        repeat (60) begin
            @(negedge clk);
            saw_done |= ifa.done | ifa.busy;
        end
        chk("no_done_after_rst", saw_done, 0);
        sweep(0, 2, EXP ^ 16'h0100, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
